exec_unit: RTL and testbench

- Parametrised E-stage execute unit for the pipelined MIPS-style CPU; successor to the single-cycle 32-bit ALU.
- Keeps the combinational ALU ops and their overflow-exception mapping.
- Adds a multi-cycle multiply/divide path with architectural HI/LO registers and a busy signal, so hazard logic can stall MD-class instructions.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/exec_unit_md_unit.sv | 104 ++++++++++
 rtl/exec_unit.sv | 96 +++++++++
 tb/tb_exec_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the E-stage execute unit: ALU ops, exception codes, MD FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_OR    = 4'd2,
        OP_AND   = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLTU  = 4'd5,
        OP_ADDO  = 4'd6,
        OP_LUI   = 4'd7,
        OP_MULT  = 4'd8,
        OP_MULTU = 4'd9,
        OP_DIV   = 4'd10,
        OP_DIVU  = 4'd11,
        OP_MFHI  = 4'd12,
        OP_MFLO  = 4'd13,
        OP_MTHI  = 4'd14,
        OP_MTLO  = 4'd15
    } alu_op_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/exec_unit_md_unit.sv
// Multiply/divide unit: HI/LO registers, pending result, latency counter and IDLE/BUSY FSM.
module md_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  alu_op_e          op,
    input  logic             accept,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    md_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   pend;
    logic [2*WIDTH-1:0]   md_res;
    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;

    assign a_sx = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign busy = (state == ST_BUSY);

    // Full {HI,LO} result, including the divide-by-zero and MIN/-1 corner cases
    always_comb begin
        md_res = '0;
        case (op)
            OP_MULT:  md_res = a_sx * b_sx;
            OP_MULTU: md_res = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
            OP_DIV: begin
                if (src_b == '0)
                    md_res = {src_a, ONES};
                else if (src_a == SMIN && src_b == ONES)
                    md_res = {{WIDTH{1'b0}}, SMIN};
                else
                    md_res = {WIDTH'($signed(src_a) % $signed(src_b)),
                              WIDTH'($signed(src_a) / $signed(src_b))};
            end
            OP_DIVU: begin
                if (src_b == '0)
                    md_res = {src_a, ONES};
                else
                    md_res = {src_a % src_b, src_a / src_b};
            end
            default: md_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            OP_MULT, OP_MULTU: begin
                                pend  <= md_res;
                                cnt   <= CNT_W'(MUL_CYCLES);
                                state <= ST_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend  <= md_res;
                                cnt   <= CNT_W'(DIV_CYCLES);
                                state <= ST_BUSY;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Last busy cycle: commit the pending result
                    if (cnt == CNT_W'(1)) begin
                        {hi, lo} <= pend;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exec_unit.sv
// E-stage execute unit: combinational ALU with overflow exception mapping plus multi-cycle MD path.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_op,
    input  logic             issue,
    input  logic [4:0]       exc_in,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       exc_out,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_op_e          op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             ovf;
    logic             accept;

    assign op   = alu_op_e'(alu_op);
    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    assign ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1]  != src_a[WIDTH-1]);
    assign ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

    // Faulting instructions never reach HI/LO; the MD unit also gates on its own idle state
    assign accept = issue && (exc_in == EXC_NONE);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD:  result = sum;
            OP_ADDO: begin
                result = sum;
                ovf    = ovf_add;
            end
            OP_SUB: begin
                result = diff;
                ovf    = ovf_sub;
            end
            OP_OR:   result = src_a | src_b;
            OP_AND:  result = src_a & src_b;
            OP_SLT:  result = WIDTH'($signed(src_a) < $signed(src_b));
            OP_SLTU: result = WIDTH'(src_a < src_b);
            OP_LUI:  result = src_b << 16;
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    // Overflow on a memory-address computation is reported as an address error
    always_comb begin
        exc_out = exc_in;
        if (ovf) begin
            if (mem_write)
                exc_out = EXC_ADES;
            else if (mem_to_reg)
                exc_out = EXC_ADEL;
            else
                exc_out = EXC_OV;
        end
    end

    md_unit #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .src_a  (src_a),
        .src_b  (src_b),
        .op     (op),
        .accept (accept),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned MULN = 5;
    localparam int unsigned DIVN = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  src_a, src_b;
    logic [3:0]    alu_op;
    logic          issue;
    logic [4:0]    exc_in;
    logic          mem_write, mem_to_reg;
    logic [W-1:0]  result;
    logic [4:0]    exc_out;
    logic          busy;
    logic [W-1:0]  hi, lo;

    exec_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_op     (alu_op),
        .issue      (issue),
        .exc_in     (exc_in),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .result     (result),
        .exc_out    (exc_out),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Architectural model: HI/LO, a pending result and the cycle at which it lands
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    bit           m_pend = 1'b0;
    int           cyc = 0;
    int           commit_at = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU) ||
               (o == OP_MTHI) || (o == OP_MTLO);
    endfunction

    function automatic logic [63:0] md_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] r  = 64'd0;
        case (o)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = ua * ub;
            OP_DIV:   r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default:  r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] h, input logic [31:0] l);
        logic [31:0] r = 32'd0;
        case (o)
            OP_ADD, OP_ADDO: r = a + b;
            OP_SUB:  r = a - b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_LUI:  r = {b[15:0], 16'd0};
            OP_MFHI: r = h;
            OP_MFLO: r = l;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] exc_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] ei, input logic mw, input logic mr);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        bit     ov = 1'b0;
        if (o == OP_ADDO) r = sa + sb;
        if (o == OP_SUB)  r = sa - sb;
        if (o == OP_ADDO || o == OP_SUB)
            ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (!ov) return ei;
        return mw ? 5'd5 : (mr ? 5'd4 : 5'd12);
    endfunction

    // Model update at each active edge
    always @(posedge clk) begin
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= 1'b0;
        end else if (m_pend) begin
            if (cyc == commit_at) begin
                m_hi   <= p_hi;
                m_lo   <= p_lo;
                m_pend <= 1'b0;
            end
        end else if (issue && exc_in == 5'd0) begin
            if (alu_op == OP_MTHI) m_hi <= src_a;
            if (alu_op == OP_MTLO) m_lo <= src_a;
            if (alu_op == OP_MULT || alu_op == OP_MULTU || alu_op == OP_DIV || alu_op == OP_DIVU) begin
                {p_hi, p_lo} <= md_model(alu_op, src_a, src_b);
                m_pend       <= 1'b1;
                commit_at    <= cyc + ((alu_op == OP_MULT || alu_op == OP_MULTU) ? int'(MULN) : int'(DIVN));
            end
        end
        cyc <= cyc + 1;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_result", result,  alu_model(alu_op, src_a, src_b, m_hi, m_lo));
            chk("m_exc",    exc_out, exc_model(alu_op, src_a, src_b, exc_in, mem_write, mem_to_reg));
            chk("m_busy",   busy,    m_pend);
            chk("m_hi",     hi,      m_hi);
            chk("m_lo",     lo,      m_lo);
            chk("md_while_busy", issue && busy && is_md(alu_op), 0);
        end
    end

    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ei, input logic mw, input logic mr, input logic iss);
        alu_op = o; src_a = a; src_b = b; exc_in = ei;
        mem_write = mw; mem_to_reg = mr; issue = iss;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        drive(OP_ADD, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          bcnt;
        logic [3:0]  o;
        logic [4:0]  ei;
        logic [4:0]  exc_pick [4];
        exc_pick[0] = 5'd4; exc_pick[1] = 5'd5; exc_pick[2] = 5'd12; exc_pick[3] = 5'd7;

        reset = 1'b1;
        drive(OP_ADD, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        step();
        reset = 1'b0;

        // Overflow mapping
        drive(OP_ADDO, 32'h7FFF_FFFF, 1, 0, 0, 0, 1);
        @(negedge clk); chk("addo_res", result, 32'h8000_0000); chk("addo_ov", exc_out, 12); step();
        drive(OP_ADDO, 32'h7FFF_FFFF, 1, 0, 1, 0, 1);
        @(negedge clk); chk("addo_ades", exc_out, 5); step();
        drive(OP_ADDO, 32'h7FFF_FFFF, 1, 0, 0, 1, 1);
        @(negedge clk); chk("addo_adel", exc_out, 4); step();
        drive(OP_ADD, 32'h7FFF_FFFF, 1, 7, 0, 0, 1);
        @(negedge clk); chk("add_pass", exc_out, 7); step();
        drive(OP_SUB, 32'h8000_0000, 1, 0, 0, 0, 1);
        @(negedge clk); chk("sub_ov", exc_out, 12); chk("sub_res", result, 32'h7FFF_FFFF); step();

        // Signed vs unsigned compare
        drive(OP_SLT, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
        @(negedge clk); chk("slt", result, 1); step();
        drive(OP_SLTU, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
        @(negedge clk); chk("sltu", result, 0); step();
        drive(OP_LUI, 0, 32'h0000_ABCD, 0, 0, 0, 1);
        @(negedge clk); chk("lui", result, 32'hABCD_0000); step();

        // MULT latency and result
        drive(OP_MULT, 32'hFFFF_FFFE, 3, 0, 0, 0, 1);
        step();
        drive(OP_ADD, 0, 0, 0, 0, 0, 0);
        bcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bcnt += int'(busy);
            step();
        end
        drive(OP_MFLO, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("mult_busy_len", bcnt, 5); chk("mult_c6_busy", busy, 0); chk("mult_lo", result, 32'hFFFF_FFFA);
        step();
        drive(OP_MFHI, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk("mult_hi", result, 32'hFFFF_FFFF); step();

        drive(OP_MULTU, 32'hFFFF_FFFE, 3, 0, 0, 0, 1);
        step();
        bubbles(5);
        @(negedge clk); chk("multu_hi", hi, 32'h0000_0002); chk("multu_lo", lo, 32'hFFFF_FFFA);
        step();

        // Divide cases
        drive(OP_DIV, 32'hFFFF_FFF9, 2, 0, 0, 0, 1);
        step();
        bubbles(9);
        @(negedge clk); chk("div_c10_busy", busy, 1);
        step();
        @(negedge clk);
        chk("div_c11_busy", busy, 0); chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);
        step();
        drive(OP_DIV, 5, 0, 0, 0, 0, 1);
        step();
        bubbles(10);
        @(negedge clk); chk("div0_lo", lo, 32'hFFFF_FFFF); chk("div0_hi", hi, 5);
        step();
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1);
        step();
        bubbles(10);
        @(negedge clk); chk("divmin_lo", lo, 32'h8000_0000); chk("divmin_hi", hi, 0);
        step();

        // MTHI gated by incoming exception
        drive(OP_MTHI, 32'h1234, 0, 12, 0, 0, 1);
        step();
        drive(OP_ADD, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("mthi_exc_hi", hi, 0);
        step();
        drive(OP_MTHI, 32'h1234, 0, 0, 0, 0, 1);
        step();
        drive(OP_ADD, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("mthi_hi", hi, 32'h1234); chk("mthi_busy", busy, 0);
        step();

        // Reset during a DIVU discards the pending result
        drive(OP_DIVU, 100, 7, 0, 0, 0, 1);
        step();
        bubbles(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk); chk("rst_mid_busy", busy, 0); chk("rst_mid_hi", hi, 0); chk("rst_mid_lo", lo, 0);
        step();
        bubbles(12);
        @(negedge clk); chk("rst_nocommit_hi", hi, 0); chk("rst_nocommit_lo", lo, 0);
        step();

        // Randomized traffic, MD-class ops held back while busy
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            o = 4'($urandom_range(0, 15));
            if (m_pend && is_md(o)) o = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0 && !m_pend) o = OP_MFHI + 4'($urandom_range(0, 1));
            ei = ($urandom_range(0, 7) == 0) ? exc_pick[$urandom_range(0, 3)] : 5'd0;
            drive(o, rnd_val(), rnd_val(), ei, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) != 0));
            step();
        end
        reset = 1'b0;
        bubbles(12);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
